// File: rtl/chinpo_mc_control_v2_if.sv
// Control bundle between the CHINPO multicycle controller and its datapath:
// IR/comparator/memory status in, datapath enables and selects out.
interface chinpo_mc_control_v2_if #(
    parameter int OPCODE_W  = 4,
    parameter int ALUSRCB_W = 3
);
    logic [OPCODE_W-1:0]  Opcode;
    logic                 Branch;
    logic [3:0]           IR;
    logic                 MemReady;
    logic                 Stall;

    logic                 PCWrite;
    logic                 IRWrite;
    logic                 RegWrite;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 MemAddr;
    logic                 WriteDataSrc;
    logic                 ALUSrcA;
    logic [ALUSRCB_W-1:0] ALUSrcB;
    logic [1:0]           ALUOp;
    logic                 MVA;
    logic                 MVB;
    logic                 CLRA;
    logic                 CLRB;
    logic                 Fault;
    logic [3:0]           current_state;
    logic [3:0]           next_state;

    // Datapath side: drives status, receives control.
    modport master (
        output Opcode, Branch, IR, MemReady, Stall,
        input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemAddr,
        input  WriteDataSrc, ALUSrcA, ALUSrcB, ALUOp,
        input  MVA, MVB, CLRA, CLRB, Fault, current_state, next_state
    );

    // Controller side: receives status, drives control.
    modport slave (
        input  Opcode, Branch, IR, MemReady, Stall,
        output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemAddr,
        output WriteDataSrc, ALUSrcA, ALUSrcB, ALUOp,
        output MVA, MVB, CLRA, CLRB, Fault, current_state, next_state
    );
endinterface

// File: rtl/chinpo_mc_control_v2.sv
// CHINPO multicycle control FSM: sequences fetch/decode/execute, waits on the
// memory-ready handshake with a bounded wait counter, and locks into a sticky
// FAULT state on timeout or an illegal opcode until Reset.
module chinpo_mc_control_v2 #(
    parameter int OPCODE_W      = 4,
    parameter int ALUSRCB_W     = 3,
    parameter int MEM_HANDSHAKE = 1,
    parameter int MAX_WAIT      = 15
) (
    input  logic                    CLK,
    input  logic                    Reset,
    chinpo_mc_control_v2_if.slave   bus
);
    localparam int WAIT_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam bit TIMEOUT_EN = (MAX_WAIT > 0);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,  DECODE   = 4'd1,  DR       = 4'd2,  I_ST     = 4'd3,
        SW_ADDR   = 4'd4,  BEQ      = 4'd5,  J_ST     = 4'd6,  JR       = 4'd7,
        DR_WRITE  = 4'd8,  SW_WRITE = 4'd9,  LW_READ  = 4'd10, LW_WRITE = 4'd11,
        JAL       = 4'd12, RESET_ST = 4'd13, FAULT_ST = 4'd14
    } state_t;

    state_t            state_r;
    state_t            next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              mem_ready_s;
    logic              op_illegal_s;
    logic              wait_cycle_s;
    logic              timeout_s;
    logic [3:0]        op_s;

    // Without the handshake every memory access completes in one cycle.
    assign mem_ready_s = (MEM_HANDSHAKE != 0) ? bus.MemReady : 1'b1;
    assign op_s        = bus.Opcode[3:0];

    generate
        if (OPCODE_W > 4) begin : g_wide_op
            assign op_illegal_s = |bus.Opcode[OPCODE_W-1:4];
        end else begin : g_narrow_op
            assign op_illegal_s = 1'b0;
        end
    endgenerate

    // A wait cycle is a non-stalled cycle in a memory state with memory not ready.
    always_comb begin
        wait_cycle_s = 1'b0;
        if ((state_r == FETCH && !bus.Stall) || state_r == LW_READ || state_r == SW_WRITE) begin
            wait_cycle_s = !mem_ready_s;
        end else begin
            wait_cycle_s = 1'b0;
        end
    end

    assign timeout_s = TIMEOUT_EN && wait_cycle_s && (wait_cnt_r == WAIT_W'(MAX_WAIT));

    // Next-state decode; opcode is read straight from the IR-held field.
    always_comb begin
        next_s = state_r;
        case (state_r)
            FETCH: begin
                if (timeout_s)                        next_s = FAULT_ST;
                else if (mem_ready_s && !bus.Stall)   next_s = DECODE;
                else                                  next_s = FETCH;
            end
            DECODE: begin
                if (op_illegal_s) begin
                    next_s = FAULT_ST;
                end else begin
                    case (op_s)
                        4'd3:                               next_s = JR;
                        4'd4, 4'd9, 4'd10, 4'd13:           next_s = I_ST;
                        4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: next_s = DR;
                        4'd8, 4'd11:                        next_s = J_ST;
                        4'd14, 4'd15:                       next_s = SW_ADDR;
                        4'd12:                              next_s = bus.Branch ? BEQ : FETCH;
                        default:                            next_s = FAULT_ST;
                    endcase
                end
            end
            DR, I_ST:  next_s = DR_WRITE;
            SW_ADDR: begin
                // Only 14/15 reach here; anything else means the IR changed under us.
                if (op_s == 4'd15)      next_s = SW_WRITE;
                else if (op_s == 4'd14) next_s = LW_READ;
                else                    next_s = FAULT_ST;
            end
            BEQ:       next_s = FETCH;
            JR:        next_s = J_ST;
            J_ST:      next_s = (op_s == 4'd11) ? JAL : FETCH;
            DR_WRITE, JAL, LW_WRITE: next_s = FETCH;
            SW_WRITE: begin
                if (timeout_s)        next_s = FAULT_ST;
                else if (mem_ready_s) next_s = FETCH;
                else                  next_s = SW_WRITE;
            end
            LW_READ: begin
                if (timeout_s)        next_s = FAULT_ST;
                else if (mem_ready_s) next_s = LW_WRITE;
                else                  next_s = LW_READ;
            end
            RESET_ST:  next_s = FETCH;
            FAULT_ST:  next_s = FAULT_ST;
            default:   next_s = FAULT_ST;
        endcase
    end

    // State register and wait counter; counter restarts on every state change.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r    <= RESET_ST;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            state_r <= next_s;
            if (next_s != state_r) begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end else if (TIMEOUT_EN && wait_cycle_s) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Datapath controls decoded from the current state, gated by memory ready.
    always_comb begin
        bus.PCWrite      = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.MemAddr      = 1'b0;
        bus.WriteDataSrc = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = {ALUSRCB_W{1'b0}};
        bus.ALUOp        = 2'd0;
        bus.MVA          = 1'b0;
        bus.MVB          = 1'b0;
        bus.CLRA         = 1'b0;
        bus.CLRB         = 1'b0;
        bus.Fault        = 1'b0;
        case (state_r)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = ALUSRCB_W'(3'd4);
                bus.ALUOp   = 2'd2;
                bus.IRWrite = mem_ready_s & ~bus.Stall;
                bus.PCWrite = mem_ready_s & ~bus.Stall;
            end
            DECODE: begin
                bus.ALUSrcB = ALUSRCB_W'(3'd3);
                bus.ALUOp   = 2'd0;
            end
            DR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'd1;
                {bus.MVA, bus.MVB, bus.CLRA, bus.CLRB} = bus.IR;
            end
            I_ST, SW_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = ALUSRCB_W'(3'd3);
                bus.ALUOp   = (state_r == I_ST) ? 2'd2 : 2'd0;
            end
            BEQ: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'd1;
                bus.PCWrite = 1'b1;
            end
            JR: begin
                bus.ALUOp = 2'd3;
                {bus.MVA, bus.MVB, bus.CLRA, bus.CLRB} = bus.IR;
            end
            J_ST: begin
                bus.ALUOp   = 2'd3;
                bus.PCWrite = 1'b1;
            end
            DR_WRITE, JAL: bus.RegWrite = 1'b1;
            SW_WRITE: begin
                bus.MemAddr  = 1'b1;
                bus.MemWrite = mem_ready_s;
            end
            LW_READ: begin
                bus.MemAddr = 1'b1;
                bus.MemRead = 1'b1;
            end
            LW_WRITE: begin
                bus.RegWrite     = 1'b1;
                bus.WriteDataSrc = 1'b1;
            end
            FAULT_ST: bus.Fault = 1'b1;
            default:  bus.Fault = 1'b0;
        endcase
    end

    assign bus.current_state = state_r;
    assign bus.next_state    = next_s;
endmodule
